// File: rtl/dram_pkg.sv
// Shared constants for the FPM DRAM bank sequencer: state encoding and 68030 byte-lane decode.
package dram_pkg;

  localparam int MA_BITS_DEF = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ROW     = 3'd1;
  localparam logic [2:0] ST_CAS     = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_REF_CAS = 3'd4;
  localparam logic [2:0] ST_REF_RAS = 3'd5;
  localparam logic [2:0] ST_PRE     = 3'd6;

  // Returns active-low CAS_n[3:0]; reads strobe every lane, writes follow the 32-bit port decode.
  function automatic logic [3:0] cas_lanes(input logic rw, input logic [1:0] siz,
                                           input logic [1:0] a10);
    logic a1, a0, s1, s0;
    logic uud, umd, lmd, lld;
    a1  = a10[1];
    a0  = a10[0];
    s1  = siz[1];
    s0  = siz[0];
    uud = ~a1 & ~a0;
    umd = (~a1 & a0) | (~a1 & ~s0) | (~a1 & s1);
    lmd = (a1 & ~a0) | (~a1 & ~s0 & ~s1) | (~a1 & s1 & s0) | (~a1 & a0 & ~s0);
    lld = (a1 & a0) | (a0 & s1 & s0) | (~s1 & ~s0) | (a1 & s1);
    if (rw) return 4'h0;
    return ~{uud, umd, lmd, lld};
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: free-running down-counter that raises a single pending flag on terminal count.
module dram_refresh_timer #(
  parameter int REFRESH_DIV = 780
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count   <= RELOAD;
      pending <= 1'b0;
    end else begin
      if (count == '0) count <= RELOAD;
      else             count <= count - CW'(1);
      // An expiry landing while a request is still outstanding is simply absorbed.
      if (clear)              pending <= 1'b0;
      else if (count == '0)   pending <= 1'b1;
    end
  end

endmodule

// File: rtl/dram_controller.sv
// FPM DRAM bank sequencer: turns 68030 bus cycles into RAS/CAS/MA/WE timing and DSACK, with CBR refresh.
//  state   | meaning
//  IDLE    | bank free, arbitrate refresh vs CPU
//  ROW     | RAS low with row address
//  CAS     | CAS low, counting to DSACK
//  HOLD    | DSACK asserted, waiting for AS_n high
//  REF_CAS | CBR: CAS low ahead of RAS
//  REF_RAS | CBR: RAS low
//  PRE     | RAS precharge
module dram_controller
  import dram_pkg::*;
#(
  parameter int MA_BITS     = MA_BITS_DEF,
  parameter int REFRESH_DIV = 780,
  parameter int CAS_CYCLES  = 2,
  parameter int RAS_PRE     = 2,
  parameter int REF_RAS     = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CS_DRAM_n,
  input  logic                   AS_n,
  input  logic                   RW,
  input  logic [1:0]             SIZ,
  input  logic [2*MA_BITS+1:0]   A,
  output logic [MA_BITS-1:0]     MA,
  output logic                   RAS_n,
  output logic [3:0]             CAS_n,
  output logic                   WE_n,
  output logic                   DSACK0_n,
  output logic                   DSACK1_n,
  output logic                   REF_ACTIVE
);

  localparam int STEP_MAX = (CAS_CYCLES > REF_RAS) ?
                            ((CAS_CYCLES > RAS_PRE) ? CAS_CYCLES : RAS_PRE) :
                            ((REF_RAS > RAS_PRE) ? REF_RAS : RAS_PRE);
  localparam int STEP_W = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam logic [STEP_W-1:0] CAS_LOAD = STEP_W'((CAS_CYCLES > 1) ? CAS_CYCLES - 2 : 0);
  localparam logic [STEP_W-1:0] PRE_LOAD = STEP_W'(RAS_PRE - 1);
  localparam logic [STEP_W-1:0] REF_LOAD = STEP_W'(REF_RAS - 1);

  logic [2:0]        state;
  logic [STEP_W-1:0] step;
  logic              req;
  logic              ref_pending;
  logic              ref_clear;

  assign req       = ~CS_DRAM_n & ~AS_n;
  assign ref_clear = (state == ST_IDLE) && ref_pending;

  dram_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_refresh_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (ref_clear),
    .pending (ref_pending)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      step       <= '0;
      MA         <= '0;
      RAS_n      <= 1'b1;
      CAS_n      <= 4'hF;
      WE_n       <= 1'b1;
      DSACK0_n   <= 1'b1;
      DSACK1_n   <= 1'b1;
      REF_ACTIVE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ref_pending) begin
            CAS_n      <= 4'h0;
            RAS_n      <= 1'b1;
            WE_n       <= 1'b1;
            REF_ACTIVE <= 1'b1;
            state      <= ST_REF_CAS;
          end else if (req) begin
            MA    <= A[2*MA_BITS+1:MA_BITS+2];
            RAS_n <= 1'b0;
            WE_n  <= RW;
            state <= ST_ROW;
          end
        end
        ST_ROW: begin
          if (AS_n) begin
            RAS_n <= 1'b1;
            WE_n  <= 1'b1;
            step  <= PRE_LOAD;
            state <= ST_PRE;
          end else begin
            MA    <= A[MA_BITS+1:2];
            CAS_n <= cas_lanes(RW, SIZ, A[1:0]);
            // DSACK lands CAS_CYCLES-1 edges after CAS so the CPU samples it with CAS low CAS_CYCLES cycles.
            if (CAS_CYCLES == 1) begin
              DSACK0_n <= 1'b0;
              DSACK1_n <= 1'b0;
              state    <= ST_HOLD;
            end else begin
              step  <= CAS_LOAD;
              state <= ST_CAS;
            end
          end
        end
        ST_CAS: begin
          if (step == '0) begin
            DSACK0_n <= 1'b0;
            DSACK1_n <= 1'b0;
            state    <= ST_HOLD;
          end else begin
            step <= step - STEP_W'(1);
          end
        end
        ST_HOLD: begin
          if (AS_n) begin
            RAS_n    <= 1'b1;
            CAS_n    <= 4'hF;
            WE_n     <= 1'b1;
            DSACK0_n <= 1'b1;
            DSACK1_n <= 1'b1;
            step     <= PRE_LOAD;
            state    <= ST_PRE;
          end
        end
        ST_REF_CAS: begin
          RAS_n <= 1'b0;
          step  <= REF_LOAD;
          state <= ST_REF_RAS;
        end
        ST_REF_RAS: begin
          if (step == '0) begin
            RAS_n <= 1'b1;
            CAS_n <= 4'hF;
            step  <= PRE_LOAD;
            state <= ST_PRE;
          end else begin
            step <= step - STEP_W'(1);
          end
        end
        ST_PRE: begin
          if (step == '0) begin
            REF_ACTIVE <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            step <= step - STEP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller with default parameters (780-cycle refresh, CAS 2, precharge 2, CBR RAS 3).
module tb_dram_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CS_DRAM_n;
  logic        AS_n;
  logic        RW;
  logic [1:0]  SIZ;
  logic [21:0] A;
  logic [9:0]  MA;
  logic        RAS_n;
  logic [3:0]  CAS_n;
  logic        WE_n;
  logic        DSACK0_n;
  logic        DSACK1_n;
  logic        REF_ACTIVE;

  int errors = 0;
  int checks = 0;

  dram_controller dut (
    .CLK(CLK), .RST(RST), .CS_DRAM_n(CS_DRAM_n), .AS_n(AS_n), .RW(RW), .SIZ(SIZ), .A(A),
    .MA(MA), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n), .DSACK0_n(DSACK0_n),
    .DSACK1_n(DSACK1_n), .REF_ACTIVE(REF_ACTIVE)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then park on the falling edge to sample outputs and drive inputs.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; CS_DRAM_n = 1'b1; AS_n = 1'b1; RW = 1'b1; SIZ = 2'b00; A = '0;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    int n;
    do_reset();
    A = 22'h00_0100; RW = 1'b1; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    tick(); tick();
    checks++; if (CAS_n !== 4'h0) begin errors++; $display("FAIL pre_reset_cas: got %h want %h", CAS_n, 4'h0); end
    RST = 1'b1;
    tick();
    checks++; if ({RAS_n, CAS_n, DSACK0_n, DSACK1_n, WE_n} !== 8'hFF) begin errors++;
      $display("FAIL reset_strobes: got %b want %b", {RAS_n, CAS_n, DSACK0_n, DSACK1_n, WE_n}, 8'hFF); end
    checks++; if ({MA, REF_ACTIVE} !== 11'h0) begin errors++;
      $display("FAIL reset_ma_ref: got %h want %h", {MA, REF_ACTIVE}, 11'h0); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    bad = 1'b0;
    repeat (2) begin tick(); if (RAS_n !== 1'b1 || CAS_n !== 4'hF) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want %b", bad, 1'b0); end
    RST = 1'b0;
    n = 0;
    while (REF_ACTIVE !== 1'b1 && n < 900) begin tick(); n++; end
    checks++; if (n !== 781) begin errors++; $display("FAIL first_refresh_edge: got %0d want %0d", n, 781); end
    checks++; if ({RAS_n, CAS_n} !== 5'b1_0000) begin errors++;
      $display("FAIL first_refresh_cbr: got %b want %b", {RAS_n, CAS_n}, 5'b1_0000); end
  endtask

  task automatic test_read();
    do_reset();
    A = 22'h12_3458; RW = 1'b1; SIZ = 2'b00; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    tick();
    checks++; if ({RAS_n, MA, WE_n, CAS_n} !== {1'b0, 10'h123, 1'b1, 4'hF}) begin errors++;
      $display("FAIL read_row: got ras=%b ma=%h we=%b cas=%h want ras=0 ma=123 we=1 cas=f", RAS_n, MA, WE_n, CAS_n); end
    tick();
    checks++; if ({MA, CAS_n, DSACK0_n, DSACK1_n} !== {10'h116, 4'h0, 2'b11}) begin errors++;
      $display("FAIL read_col: got ma=%h cas=%h dsack=%b want ma=116 cas=0 dsack=11", MA, CAS_n, {DSACK1_n, DSACK0_n}); end
    tick();
    checks++; if ({DSACK1_n, DSACK0_n, CAS_n, RAS_n} !== 7'b00_0000_0) begin errors++;
      $display("FAIL read_dsack: got %b want %b", {DSACK1_n, DSACK0_n, CAS_n, RAS_n}, 7'b0); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    tick();
    checks++; if ({RAS_n, CAS_n, DSACK1_n, DSACK0_n, WE_n} !== 8'hFF) begin errors++;
      $display("FAIL read_release: got %b want %b", {RAS_n, CAS_n, DSACK1_n, DSACK0_n, WE_n}, 8'hFF); end
  endtask

  task automatic test_write_lanes();
    logic [1:0] va [5] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
    logic [1:0] vs [5] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [3:0] ve [5] = '{4'b0111, 4'b0011, 4'b0000, 4'b1110, 4'b1000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      A = {20'h0_0040, va[i]}; SIZ = vs[i]; RW = 1'b0; CS_DRAM_n = 1'b0; AS_n = 1'b0;
      tick();
      checks++; if (WE_n !== 1'b0) begin errors++; $display("FAIL write_we[%0d]: got %b want 0", i, WE_n); end
      tick();
      checks++; if (CAS_n !== ve[i]) begin errors++;
        $display("FAIL write_lanes[%0d]: got %b want %b", i, CAS_n, ve[i]); end
      tick();
      AS_n = 1'b1; CS_DRAM_n = 1'b1; RW = 1'b1;
      repeat (3) tick();
    end
  endtask

  task automatic test_refresh_contention();
    logic bad;
    do_reset();
    repeat (780) tick();
    A = 22'h00_0200; RW = 1'b1; SIZ = 2'b00; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    tick();
    checks++; if ({REF_ACTIVE, RAS_n, CAS_n, DSACK0_n} !== 7'b1_1_0000_1) begin errors++;
      $display("FAIL contention_cbr_first: got %b want %b", {REF_ACTIVE, RAS_n, CAS_n, DSACK0_n}, 7'b1100001); end
    tick();
    checks++; if ({RAS_n, CAS_n} !== 5'b0_0000) begin errors++;
      $display("FAIL contention_cbr_ras: got %b want %b", {RAS_n, CAS_n}, 5'b0); end
    bad = 1'b0;
    for (int e = 783; e <= 789; e++) begin
      tick();
      if (DSACK0_n !== 1'b1) bad = 1'b1;
      if (e == 788) begin
        checks++; if ({REF_ACTIVE, RAS_n, CAS_n} !== 6'b0_0_1111) begin errors++;
          $display("FAIL contention_cpu_row: got %b want %b", {REF_ACTIVE, RAS_n, CAS_n}, 6'b001111); end
      end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL contention_early_dsack: got %b want 0", bad); end
    tick();
    checks++; if ({DSACK1_n, DSACK0_n} !== 2'b00) begin errors++;
      $display("FAIL contention_dsack: got %b want 00", {DSACK1_n, DSACK0_n}); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_long_hold();
    logic bad;
    do_reset();
    repeat (770) tick();
    A = 22'h00_0300; RW = 1'b1; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    repeat (3) tick();
    bad = 1'b0;
    for (int e = 773; e <= 790; e++) begin
      if (e > 773) tick();
      if ({DSACK1_n, DSACK0_n, CAS_n, RAS_n, REF_ACTIVE} !== 8'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_strobes: got %b want 0", bad); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    tick();
    checks++; if ({RAS_n, CAS_n, DSACK1_n, DSACK0_n} !== 7'h7F) begin errors++;
      $display("FAIL hold_release: got %b want %b", {RAS_n, CAS_n, DSACK1_n, DSACK0_n}, 7'h7F); end
    tick(); tick();
    checks++; if ({REF_ACTIVE, CAS_n} !== 5'b0_1111) begin errors++;
      $display("FAIL hold_precharge: got %b want %b", {REF_ACTIVE, CAS_n}, 5'b01111); end
    tick();
    checks++; if ({REF_ACTIVE, RAS_n, CAS_n} !== 6'b1_1_0000) begin errors++;
      $display("FAIL hold_queued_cbr: got %b want %b", {REF_ACTIVE, RAS_n, CAS_n}, 6'b110000); end
    tick();
    checks++; if (RAS_n !== 1'b0) begin errors++; $display("FAIL hold_cbr_ras: got %b want 0", RAS_n); end
  endtask

  task automatic test_abort();
    logic bad;
    do_reset();
    A = 22'h00_0400; RW = 1'b1; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    tick();
    checks++; if (RAS_n !== 1'b0) begin errors++; $display("FAIL abort_row: got %b want 0", RAS_n); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if ({RAS_n, CAS_n, DSACK1_n, DSACK0_n} !== 7'h7F) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_no_cas: got %b want 0", bad); end
    CS_DRAM_n = 1'b0; AS_n = 1'b0;
    tick();
    checks++; if (RAS_n !== 1'b0) begin errors++; $display("FAIL abort_next_row: got %b want 0", RAS_n); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic bad;
    do_reset();
    CS_DRAM_n = 1'b1; AS_n = 1'b0;
    bad = 1'b0;
    repeat (4) begin tick(); if (RAS_n !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL other_device_ignored: got %b want 0", bad); end
    AS_n = 1'b1;
    tick();
    A = 22'h00_0500; RW = 1'b1; CS_DRAM_n = 1'b0; AS_n = 1'b0;
    repeat (3) tick();
    AS_n = 1'b1;
    tick();
    AS_n = 1'b0;
    tick();
    checks++; if (RAS_n !== 1'b1) begin errors++; $display("FAIL b2b_pre1: got %b want 1", RAS_n); end
    tick();
    checks++; if (RAS_n !== 1'b1) begin errors++; $display("FAIL b2b_pre2: got %b want 1", RAS_n); end
    tick();
    checks++; if ({RAS_n, MA} !== {1'b0, 10'h000}) begin errors++;
      $display("FAIL b2b_second_row: got %b want %b", {RAS_n, MA}, {1'b0, 10'h000}); end
    tick(); tick();
    checks++; if ({DSACK1_n, DSACK0_n} !== 2'b00) begin errors++;
      $display("FAIL b2b_second_dsack: got %b want 00", {DSACK1_n, DSACK0_n}); end
    AS_n = 1'b1; CS_DRAM_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    RST = 1'b1; CS_DRAM_n = 1'b1; AS_n = 1'b1; RW = 1'b1; SIZ = 2'b00; A = '0;
    @(negedge CLK);
    test_reset();
    test_read();
    test_write_lanes();
    test_refresh_contention();
    test_long_hold();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
